// File: rtl/uart_rx_fsm.sv
// UART receive-path controller.
// Finds the start bit, enables the edge/bit counter and issues the sampler,
// deserializer and checker strobes at fixed oversampled edges. data_valid
// pulses in DONE when neither the parity nor the stop check failed.
// Optional macro UART_RX_ERR_FLAGS_EN adds the par_err_o and frm_err_o outputs.
module uart_rx_fsm #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  cnt_enable,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
    output logic                  par_err_o,
    output logic                  frm_err_o,
`endif
    output logic                  data_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_t;

    state_t r_state;
    logic   r_par_flag;
    logic   r_stp_flag;
`ifdef UART_RX_ERR_FLAGS_EN
    logic   r_glitch_abort;
`endif

    logic [PRESCALE_W-1:0] w_chk;
    logic [PRESCALE_W-1:0] w_chk1;
    logic [PRESCALE_W-1:0] w_last;
    logic                  w_at_chk;
    logic                  w_at_chk1;
    logic                  w_at_last;
    logic                  w_last_bit;

    // The check strobe lands one cycle after the 3-sample majority window
    assign w_chk      = (Prescale >> 1) + PRESCALE_W'(2);
    assign w_chk1     = w_chk + PRESCALE_W'(1);
    assign w_last     = Prescale - PRESCALE_W'(1);
    assign w_at_chk   = (edge_cnt == w_chk);
    assign w_at_chk1  = (edge_cnt == w_chk1);
    assign w_at_last  = (edge_cnt == w_last);
    assign w_last_bit = (bit_cnt == BIT_CNT_W'(DATA_BITS));

    // State and sticky error flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            r_glitch_abort <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_ERR_FLAGS_EN
            r_glitch_abort <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    r_par_flag <= 1'b0;
                    r_stp_flag <= 1'b0;
                    if (!RX_IN) r_state <= StStart;
                end
                StStart: begin
                    // Glitch abort takes priority: at Prescale 8, CHK+1 == LAST
                    if (w_at_chk1 && strt_glitch) begin
                        r_state <= StIdle;
`ifdef UART_RX_ERR_FLAGS_EN
                        r_glitch_abort <= 1'b1;
`endif
                    end else if (w_at_last) begin
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (w_at_last && w_last_bit) r_state <= PAR_EN ? StParity : StStop;
                end
                StParity: begin
                    if (w_at_chk1) r_par_flag <= r_par_flag | par_err;
                    if (w_at_last) r_state <= StStop;
                end
                StStop: begin
                    if (w_at_chk1) r_stp_flag <= r_stp_flag | stp_err;
                    if (w_at_last) r_state <= StDone;
                end
                StDone: begin
                    r_par_flag <= 1'b0;
                    r_stp_flag <= 1'b0;
                    r_state    <= RX_IN ? StIdle : StStart;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Output decode from state and edge position
    always_comb begin
        cnt_enable  = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
        par_err_o   = 1'b0;
        frm_err_o   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
`ifdef UART_RX_ERR_FLAGS_EN
                frm_err_o = r_glitch_abort;
`endif
            end
            StStart: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = w_at_chk;
            end
            StData: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = w_at_chk1;
            end
            StParity: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = w_at_chk;
            end
            StStop: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = w_at_chk;
            end
            StDone: begin
                data_valid = !r_par_flag && !r_stp_flag;
`ifdef UART_RX_ERR_FLAGS_EN
                par_err_o  = r_par_flag;
                frm_err_o  = r_stp_flag;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm. The bench plays the edge/bit counter
// and the start/parity/stop checkers, and predicts every output per cycle
// from the frame timeline (slot = k / Prescale, edge = k % Prescale).
module tb_uart_rx_fsm;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          cnt_enable;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic          par_err_o;
    logic          frm_err_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cfg_glitch = 1'b0;
    bit cfg_perr   = 1'b0;
    bit cfg_serr   = 1'b0;

    uart_rx_fsm #(
        .DATA_BITS (8),
        .PRESCALE_W(PW),
        .BIT_CNT_W (BW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .Prescale   (Prescale),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .cnt_enable (cnt_enable),
        .dat_samp_en(dat_samp_en),
        .deser_en   (deser_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
`ifdef UART_RX_ERR_FLAGS_EN
        .par_err_o  (par_err_o),
        .frm_err_o  (frm_err_o),
`endif
        .data_valid (data_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Edge/bit counter: wraps edge at Prescale-1, bit after the stop slot
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == Prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == (PAR_EN ? 4'd10 : 4'd9)) ? 4'd0 : bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    // Checkers: results registered on their strobe
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            if (strt_chk_en) strt_glitch <= cfg_glitch;
            if (par_chk_en)  par_err     <= cfg_perr;
            if (stp_chk_en)  stp_err     <= cfg_serr;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // {frm_err_o, par_err_o, cnt_en, samp_en, deser, strt_chk, par_chk, stp_chk, valid}
    function automatic logic [8:0] dut_vec();
        logic [8:0] v;
        v = {2'b00, cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
             data_valid};
`ifdef UART_RX_ERR_FLAGS_EN
        v[8] = frm_err_o;
        v[7] = par_err_o;
`endif
        return v;
    endfunction

    // Expected outputs k cycles after entering START
    function automatic logic [8:0] exp_out(int k, int p, bit par, bit gl, bit pe, bit se);
        int chk       = p / 2 + 2;
        int stop_slot = par ? 10 : 9;
        int done      = (stop_slot + 1) * p;
        int slot      = k / p;
        int e         = k % p;
        bit perr      = par && pe;
        logic [8:0] v = '0;
        if (gl) begin
            if (k <= chk + 1) begin
                v[6] = 1'b1;
                v[5] = 1'b1;
                v[3] = (k == chk);
            end else if (k == chk + 2) begin
                v[8] = 1'b1;
            end
        end else if (k < done) begin
            v[6] = 1'b1;
            v[5] = 1'b1;
            v[4] = (slot >= 1 && slot <= 8 && e == chk + 1);
            v[3] = (slot == 0 && e == chk);
            v[2] = (par && slot == 9 && e == chk);
            v[1] = (slot == stop_slot && e == chk);
        end else if (k == done) begin
            v[0] = !perr && !se;
            v[7] = perr;
            v[8] = se;
        end
`ifndef UART_RX_ERR_FLAGS_EN
        v[8:7] = 2'b00;
`endif
        return v;
    endfunction

    function automatic logic rx_bit(int k, int p, bit par, logic [7:0] d);
        int slot = k / p;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[3'(slot - 1)];
        if (slot == 9 && par) return ^d;
        return 1'b1;
    endfunction

    // Runs one frame; starts and ends just after a rising edge
    task automatic run_frame(input int p, input bit par, input logic [7:0] d, input bit gl,
                             input bit pe, input bit se, input bit started, input bit b2b_next,
                             input int abort_k, output int n_deser, output int n_par,
                             output int n_stp, output int n_valid, output int valid_k,
                             output int valid_cyc);
        int chk  = p / 2 + 2;
        int done = ((par ? 10 : 9) + 1) * p;
        int last_k;
        n_deser   = 0;
        n_par     = 0;
        n_stp     = 0;
        n_valid   = 0;
        valid_k   = -1;
        valid_cyc = -1;
        cfg_glitch = gl;
        cfg_perr   = pe;
        cfg_serr   = se;
        PAR_EN     = par;
        last_k = gl ? chk + 2 : (b2b_next ? done : done + 1);
        if (!started) begin
            Prescale = PW'(p);
            RX_IN    = 1'b0;
            @(negedge CLK);
            check("idle before start", 32'(dut_vec()), 32'(0));
            @(posedge CLK);
            #1;
        end
        for (int k = 0; k <= last_k; k++) begin
            if (k == abort_k) return;
            if (gl) RX_IN = (k < 3) ? 1'b0 : 1'b1;
            else if (k == done) RX_IN = b2b_next ? 1'b0 : 1'b1;
            else if (k > done) RX_IN = 1'b1;
            else RX_IN = rx_bit(k, p, par, d);
            @(negedge CLK);
            check($sformatf("outputs p=%0d k=%0d", p, k), 32'(dut_vec()),
                  32'(exp_out(k, p, par, gl, pe, se)));
            if (gl) check("glitch bit_cnt", 32'(bit_cnt), 32'(0));
            if (deser_en) n_deser++;
            if (par_chk_en) n_par++;
            if (stp_chk_en) n_stp++;
            if (data_valid) begin
                n_valid++;
                valid_k   = k;
                valid_cyc = cyc;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    typedef struct {
        int         p;
        bit         par;
        logic [7:0] d;
        bit         gl;
        bit         pe;
        bit         se;
        bit         started;
        bit         b2b;
        int         e_deser;
        int         e_par;
        int         e_stp;
        int         e_valid;
        int         e_vk;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nd, np, ns, nv, vk, vc;
        int prev_vc;
        int p;
        bit chain;
        bit par, gl, pe, se, b2b;

        tbl[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 1, 80};
        tbl[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1, 1, 0, -1};
        tbl[2] = '{16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, -1};
        tbl[3] = '{32, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 0, 1, 0, -1};
        tbl[4] = '{32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1, 1, 320};
        tbl[5] = '{8,  1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0, 1, 1, 80};
        tbl[6] = '{8,  1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 0, 1, 1, 80};
        tbl[7] = '{16, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 1, 1, 176};

        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        Prescale = 6'd8;
        #1;
        check("reset held", 32'(dut_vec()), 32'(0));
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("first cycle after reset", 32'(dut_vec()), 32'(0));
        @(posedge CLK);
        #1;

        prev_vc = 0;
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].p, tbl[i].par, tbl[i].d, tbl[i].gl, tbl[i].pe, tbl[i].se,
                      tbl[i].started, tbl[i].b2b, -1, nd, np, ns, nv, vk, vc);
            check($sformatf("vec%0d deser count", i), 32'(nd), 32'(tbl[i].e_deser));
            check($sformatf("vec%0d par_chk count", i), 32'(np), 32'(tbl[i].e_par));
            check($sformatf("vec%0d stp_chk count", i), 32'(ns), 32'(tbl[i].e_stp));
            check($sformatf("vec%0d valid count", i), 32'(nv), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d valid k", i), 32'(vk), 32'(tbl[i].e_vk));
            if (i == 6) check("back-to-back valid spacing", 32'(vc - prev_vc), 32'(81));
            prev_vc = vc;
        end

        // Async reset in the middle of data bit 4
        run_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3, nd, np, ns, nv, vk,
                  vc);
        check("pre-reset deser count", 32'(nd), 32'(3));
        RX_IN = 1'b1;
        RST   = 1'b1;
        #1;
        check("async reset outputs", 32'(dut_vec()), 32'(0));
        @(posedge CLK);
        @(negedge CLK);
        check("reset held mid-frame", 32'(dut_vec()), 32'(0));
        RST = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("first cycle after mid reset", 32'(dut_vec()), 32'(0));
        @(posedge CLK);
        #1;
        run_frame(8, 1'b0, 8'h3E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, nd, np, ns, nv, vk, vc);
        check("post-reset valid count", 32'(nv), 32'(1));
        check("post-reset deser count", 32'(nd), 32'(8));

        // Randomized frames against the timeline model
        chain = 1'b0;
        p     = 8;
        for (int i = 0; i < 30; i++) begin
            if (!chain) p = 8 << $urandom_range(0, 2);
            par = 1'($urandom_range(0, 1));
            gl  = ($urandom_range(0, 7) == 0);
            pe  = ($urandom_range(0, 3) == 0);
            se  = ($urandom_range(0, 3) == 0);
            b2b = !gl && (i != 29) && ($urandom_range(0, 2) == 0);
            run_frame(p, par, 8'($urandom), gl, pe, se, chain, b2b, -1, nd, np, ns, nv, vk, vc);
            check($sformatf("rand%0d deser count", i), 32'(nd), gl ? 32'(0) : 32'(8));
            check($sformatf("rand%0d valid count", i), 32'(nv),
                  32'((!gl && !(par && pe) && !se) ? 1 : 0));
            chain = b2b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
